// File: rtl/dma_pkg.sv
// Shared definitions for the DMA reader and writer: constant AXI3 read/write
// attribute values, the fixed burst length and the common three-state FSM enum.
package dma_pkg;

    localparam logic [1:0] BURST_INCR    = 2'b01;
    localparam logic [2:0] SIZE_8B       = 3'b011;
    localparam logic [3:0] CACHE_DEFAULT = 4'b0011;
    localparam logic [2:0] PROT_DEFAULT  = 3'b000;
    localparam int         BURST_BEATS   = 16;
    localparam logic [3:0] BURST_LEN     = 4'(BURST_BEATS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } dma_state_e;

endpackage

// File: rtl/dma_addr_gen.sv
// Buffer-index latch, beat counter and DDR address arithmetic for one buffer
// transfer. rst_i is synchronous and active-low. The beat counter wraps
// modulo 2^BUF_BEATS_LOG2; burstEnd_o flags the last beat of a 16-beat burst
// and bufferEnd_o flags the last beat of the whole buffer.
module dma_addr_gen
    import dma_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR      = 32'h1000_0000,
    parameter int          BUF_BEATS_LOG2 = 12,
    parameter int          NBUF_LOG2      = 6
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      load_i,
    input  logic [NBUF_LOG2-1:0]      buffer_i,
    input  logic                      advance_i,
    output logic [BUF_BEATS_LOG2-1:0] beat_o,
    output logic [31:0]               addr_o,
    output logic                      burstEnd_o,
    output logic                      bufferEnd_o
);

    logic [NBUF_LOG2-1:0]      buffer_q, buffer_d;
    logic [BUF_BEATS_LOG2-1:0] beat_q, beat_d;

    // A new transfer latches the buffer and restarts at beat 0; each accepted beat advances.
    always_comb begin
        buffer_d = buffer_q;
        beat_d   = beat_q;
        if (load_i) begin
            buffer_d = buffer_i;
            beat_d   = '0;
        end else if (advance_i) begin
            beat_d = beat_q + 1'b1;
        end
    end

    // Buffer index and beat counter registers, cleared by reset.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            buffer_q <= '0;
            beat_q   <= '0;
        end else begin
            buffer_q <= buffer_d;
            beat_q   <= beat_d;
        end
    end

    assign beat_o      = beat_q;
    assign addr_o      = BASE_ADDR
                       + (32'(buffer_q) << (BUF_BEATS_LOG2 + 3))
                       + (32'(beat_q) << 3);
    assign burstEnd_o  = (beat_q[3:0] == BURST_LEN);
    assign bufferEnd_o = (beat_q == {BUF_BEATS_LOG2{1'b1}});

endmodule

// File: rtl/dma_reader.sv
// DMA reader: copies one DDR buffer into local RAM using 16-beat AXI3 INCR
// read bursts, one burst outstanding at a time. Each accepted R beat is
// written to local RAM one cycle later. Optional feature macro
// DMA_READER_ERROR_EN enables the sticky error flag on bad rresp/rlast.
module dma_reader
    import dma_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR      = 32'h1000_0000,
    parameter int          BUF_BEATS_LOG2 = 12,
    parameter int          NBUF_LOG2      = 6
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [NBUF_LOG2-1:0]      buffer,
    output logic                      busy,
    output logic                      done,
    output logic [31:0]               araddr,
    output logic [3:0]                arlen,
    output logic [2:0]                arsize,
    output logic [1:0]                arburst,
    output logic [3:0]                arcache,
    output logic [2:0]                arprot,
    output logic                      arvalid,
    input  logic                      arready,
    input  logic [63:0]               rdata,
    input  logic [1:0]                rresp,
    input  logic                      rlast,
    input  logic                      rvalid,
    output logic                      rready,
    output logic [BUF_BEATS_LOG2-1:0] waddr,
    output logic [63:0]               wdata,
    output logic                      wen,
    output logic                      error
);

    dma_state_e                state_q, state_d;
    logic                      done_q, done_d;
    logic                      wen_q;
    logic [BUF_BEATS_LOG2-1:0] waddr_q;
    logic [63:0]               wdata_q;

    logic                      accept;
    logic                      beatHs;
    logic [BUF_BEATS_LOG2-1:0] beat;
    logic [31:0]               nextAddr;
    logic                      burstEnd;
    logic                      bufferEnd;

    // The done cycle is already IDLE, so a start there must be masked explicitly.
    assign accept = (state_q == IDLE) && start && !done_q;
    assign beatHs = rvalid && (state_q == DATA);

    dma_addr_gen #(
        .BASE_ADDR      (BASE_ADDR),
        .BUF_BEATS_LOG2 (BUF_BEATS_LOG2),
        .NBUF_LOG2      (NBUF_LOG2)
    ) u_addrGen (
        .clk_i       (clk),
        .rst_i       (rst),
        .load_i      (accept),
        .buffer_i    (buffer),
        .advance_i   (beatHs),
        .beat_o      (beat),
        .addr_o      (nextAddr),
        .burstEnd_o  (burstEnd),
        .bufferEnd_o (bufferEnd)
    );

    // Next-state and channel handshake outputs; the 16th beat ends a burst regardless of rlast.
    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        busy    = (state_q != IDLE);
        arvalid = 1'b0;
        rready  = 1'b0;
        araddr  = 32'h0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = ADDR;
                end
            end
            ADDR: begin
                arvalid = 1'b1;
                araddr  = nextAddr;
                if (arready) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                rready = 1'b1;
                if (rvalid && burstEnd) begin
                    if (bufferEnd) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ADDR;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register plus the one-cycle-delayed local RAM write port.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
            wen_q   <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            wen_q   <= beatHs;
            if (beatHs) begin
                waddr_q <= beat;
                wdata_q <= rdata;
            end
        end
    end

    assign done    = done_q;
    assign wen     = wen_q;
    assign waddr   = waddr_q;
    assign wdata   = wdata_q;
    assign arlen   = BURST_LEN;
    assign arsize  = SIZE_8B;
    assign arburst = BURST_INCR;
    assign arcache = CACHE_DEFAULT;
    assign arprot  = PROT_DEFAULT;

`ifdef DMA_READER_ERROR_EN
    logic error_q, error_d;

    // Error is sticky for the whole transfer and only cleared by the next accepted start.
    always_comb begin
        error_d = error_q;
        if (accept) begin
            error_d = 1'b0;
        end else if (beatHs && ((rresp != 2'b00) || (rlast != burstEnd))) begin
            error_d = 1'b1;
        end
    end

    // Error flag register, cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            error_q <= 1'b0;
        end else begin
            error_q <= error_d;
        end
    end

    assign error = error_q;
`else
    logic unusedRsp;
    assign unusedRsp = ^{rresp, rlast};
    assign error     = 1'b0;
`endif

endmodule
